decode_pipe: RTL and testbench
==============================

# decode_pipe

Parametrised, pipelined decode stage that sits between fetch and execute. It latches fetched instructions behind a valid/ready handshake and reads the register file. It produces registered operands, a sign-extended immediate and a branch target. It also detects load-use hazards and inserts bubbles, accepts flushes, and optionally bypasses same-cycle writeback data onto the read ports.

## Interface
Parameters:
- DATA_W, 16: datapath width for registers, PC, immediates and branch target; must be at least 16.
- NREG_W, 4: register address width; the file holds 2**NREG_W entries and register 0 reads as zero.

Ports:
- clk  in  1  single clock; everything updates on the rising edge.
- rst  in  1  reset, synchronous and active-low.
- in_valid  in  1  fetch presents an instruction.
- in_ready  out  1  the stage accepts on this edge when in_valid && in_ready.
- instr  in  16  instruction; src1 = instr[7:4]; src2 = instr[11:8] when reg_src, else instr[3:0].
- pc  in  DATA_W  PC of the instruction.
- imm_size  in  1  0 selects a 4-bit immediate instr[3:0]; 1 selects a 9-bit immediate instr[8:0].
- reg_src  in  1  src2 field select, sampled with instr.
- branch_src  in  1  1 selects register target (rdata1); 0 selects PC-relative target. Sampled with instr.
- flush  in  1  squash all in-flight instructions in this stage.
- wb_en, wb_reg, wb_data  in  1/NREG_W/DATA_W  writeback port.
- ex_load_valid, ex_load_reg  in  1/NREG_W  a load currently in execute and its destination register.
- out_valid  out  1  ID/EX register holds a valid instruction.
- out_ready  in  1  execute consumes on this edge when out_valid && out_ready.
- out_rdata1, out_rdata2, out_imm, out_pc_branch, out_pc  out  DATA_W  registered results.
- out_src1, out_src2  out  NREG_W  registered source addresses, for downstream forwarding.

## Operation
- Two registers form the stage: the ID latch (instr, pc, control bits, valid) and the ID/EX register (outputs).
- Register file: 2**NREG_W x DATA_W. A write is ignored when wb_reg == 0. A read of register 0 returns 0.
- Immediate:
  - 4-bit or 9-bit field, sign-extended to DATA_W.
  - Branch target = pc + (imm << 1), computed modulo 2**DATA_W; carry is discarded.
  - When branch_src = 1, out_pc_branch = read data 1 instead.
- Hazard condition, evaluated on the ID latch contents:
  - ID latch is valid, ex_load_valid = 1, ex_load_reg != 0, and ex_load_reg equals src1 or src2.
  - While it holds, the ID latch keeps its contents and in_ready = 0.
  - The ID/EX register loads a bubble (out_valid = 0) if it is free.
- Advance: the ID latch moves to ID/EX when it is valid, there is no hazard, and (!out_valid || out_ready).
- Backpressure:
  - in_ready = !flush && (!id_valid || advance).
  - If out_valid && !out_ready, the ID/EX register holds.
- Flush:
  - At the edge, id_valid and out_valid clear to 0.
  - in_ready is 0 during the flush cycle, so no instruction is accepted.
  - A writeback in the same cycle still commits.
- Reset, sampled with rst = 0 at an edge:
  - All valids, outputs and registers return to 0.
  - This applies mid-stall and mid-backpressure. Reset overrides flush and writeback.

## Timing
- Latency: an instruction accepted at edge k appears on the outputs after edge k+1 when there is no hazard or backpressure.
- Throughput: one instruction per cycle.
- Each hazard cycle adds exactly one bubble. The load leaving execute clears the hazard on the next cycle.
- Register reads are combinational from the ID latch and are captured into ID/EX at the advance edge.
- A register write becomes visible to reads in the cycle after the write edge, unless bypass is enabled.

## Configuration
- DECODE_BYPASS_EN defined:
  - When wb_en && wb_reg != 0 && wb_reg matches a source, the read data for that source is wb_data in the same cycle.
  - This applies to both read ports and to the branch_src register target.
- DECODE_BYPASS_EN undefined:
  - That match is an extra hazard term: a one-cycle stall, after which the value is read from the file.

## Test plan
- Reset mid-stream:
  - Stimulus: fill both stages, then hold rst = 0 for one edge.
  - Response: out_valid = 0, all outputs 0, in_ready = 1, and r1..r15 read 0.
- Immediates and branch, DATA_W = 16:
  - Stimulus: pc = 0x0010, imm_size = 1, instr[8:0] = 0x1FE.
  - Response: out_imm = 0xFFFE, out_pc_branch = 0x000C.
  - Stimulus: pc = 0xFFFE, imm = +2.
  - Response: target wraps to 0x0002.
- Load-use:
  - Stimulus: ex_load_reg = 3 with src1 = 3.
  - Response: exactly one bubble; in_ready = 0 for one cycle; then the instruction issues with the r3 value written meanwhile.
- Bypass:
  - Stimulus: wb r5 = 0x1234 in the same cycle the instruction reads r5.
  - Response with DECODE_BYPASS_EN defined: out_rdata2 = 0x1234, no stall.
  - Response without it: one stall, then 0x1234.
- Backpressure and flush:
  - Stimulus: out_ready = 0 for 3 cycles.
  - Response: outputs stable and in_ready = 0 once the ID latch is full.
  - Stimulus: flush during that hold.
  - Response: both valids are 0 at the next edge, and the concurrent wb is committed.
- Register 0 and wide datapath:
  - Stimulus: write r0 = 0xFFFF.
  - Response: r0 still reads 0.
  - Stimulus: repeat the immediate test with DATA_W = 32.
  - Response: sign extension to 32 bits, e.g. 0xFFFFFFFE.

Source files
------------

// File: rtl/decode_pipe.sv
// Pipelined decode stage: ID latch + ID/EX register, register file, immediates, branch target, load-use stall.
// Optional feature macro DECODE_BYPASS_EN: same-cycle writeback bypass onto the read ports.
module decode_pipe #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned NREG_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [15:0]       instr,
  input  logic [DATA_W-1:0] pc,
  input  logic              imm_size,
  input  logic              reg_src,
  input  logic              branch_src,
  input  logic              flush,
  input  logic              wb_en,
  input  logic [NREG_W-1:0] wb_reg,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              ex_load_valid,
  input  logic [NREG_W-1:0] ex_load_reg,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_rdata1,
  output logic [DATA_W-1:0] out_rdata2,
  output logic [DATA_W-1:0] out_imm,
  output logic [DATA_W-1:0] out_pc_branch,
  output logic [DATA_W-1:0] out_pc,
  output logic [NREG_W-1:0] out_src1,
  output logic [NREG_W-1:0] out_src2
);

  localparam int unsigned NREG = 1 << NREG_W;

  logic [DATA_W-1:0] r_rf [NREG];

  logic              r_id_valid;
  logic [11:0]       r_id_instr;
  logic [DATA_W-1:0] r_id_pc;
  logic              r_id_imm_size;
  logic              r_id_reg_src;
  logic              r_id_branch_src;

  logic              r_out_valid;
  logic [DATA_W-1:0] r_out_rdata1;
  logic [DATA_W-1:0] r_out_rdata2;
  logic [DATA_W-1:0] r_out_imm;
  logic [DATA_W-1:0] r_out_pc_branch;
  logic [DATA_W-1:0] r_out_pc;
  logic [NREG_W-1:0] r_out_src1;
  logic [NREG_W-1:0] r_out_src2;

  logic [NREG_W-1:0] w_src1;
  logic [NREG_W-1:0] w_src2;
  logic [DATA_W-1:0] w_rd1;
  logic [DATA_W-1:0] w_rd2;
  logic [DATA_W-1:0] w_imm;
  logic [DATA_W-1:0] w_target;
  logic [DATA_W-1:0] w_pc_branch;
  logic              w_wb_hit1;
  logic              w_wb_hit2;
  logic              w_wb_haz;
  logic              w_load_haz;
  logic              w_hazard;
  logic              w_advance;
  logic              w_in_ready;
  logic              w_unused;

  // The top opcode nibble is consumed further downstream, not here.
  assign w_unused = ^instr[15:12];

  assign w_src1 = NREG_W'(r_id_instr[7:4]);
  assign w_src2 = r_id_reg_src ? NREG_W'(r_id_instr[11:8]) : NREG_W'(r_id_instr[3:0]);

  assign w_wb_hit1 = wb_en && (wb_reg != '0) && (wb_reg == w_src1);
  assign w_wb_hit2 = wb_en && (wb_reg != '0) && (wb_reg == w_src2);

  // Register reads; without bypass a same-cycle writeback match stalls instead.
  always_comb begin
    w_rd1    = '0;
    w_rd2    = '0;
    w_wb_haz = 1'b0;
    if (w_src1 != '0) w_rd1 = r_rf[w_src1];
    if (w_src2 != '0) w_rd2 = r_rf[w_src2];
`ifdef DECODE_BYPASS_EN
    if (w_wb_hit1) w_rd1 = wb_data;
    if (w_wb_hit2) w_rd2 = wb_data;
`else
    w_wb_haz = r_id_valid && (w_wb_hit1 || w_wb_hit2);
`endif
  end

  assign w_imm = r_id_imm_size ? {{(DATA_W-9){r_id_instr[8]}}, r_id_instr[8:0]}
                               : {{(DATA_W-4){r_id_instr[3]}}, r_id_instr[3:0]};
  assign w_target    = r_id_pc + (w_imm << 1);
  assign w_pc_branch = r_id_branch_src ? w_rd1 : w_target;

  assign w_load_haz = r_id_valid && ex_load_valid && (ex_load_reg != '0) &&
                      ((ex_load_reg == w_src1) || (ex_load_reg == w_src2));
  assign w_hazard   = w_load_haz || w_wb_haz;
  assign w_advance  = r_id_valid && !w_hazard && (!r_out_valid || out_ready);
  assign w_in_ready = !flush && (!r_id_valid || w_advance);

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int unsigned i = 0; i < NREG; i++) r_rf[i] <= '0;
    end else if (wb_en && (wb_reg != '0)) begin
      r_rf[wb_reg] <= wb_data;
    end
  end

  // ID latch: holds through hazards, clears on flush or when its contents advance.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_id_valid      <= 1'b0;
      r_id_instr      <= '0;
      r_id_pc         <= '0;
      r_id_imm_size   <= 1'b0;
      r_id_reg_src    <= 1'b0;
      r_id_branch_src <= 1'b0;
    end else if (flush) begin
      r_id_valid <= 1'b0;
    end else if (in_valid && w_in_ready) begin
      r_id_valid      <= 1'b1;
      r_id_instr      <= instr[11:0];
      r_id_pc         <= pc;
      r_id_imm_size   <= imm_size;
      r_id_reg_src    <= reg_src;
      r_id_branch_src <= branch_src;
    end else if (w_advance) begin
      r_id_valid <= 1'b0;
    end
  end

  // ID/EX register: loads on advance, inserts a bubble when free, holds under backpressure.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_out_valid     <= 1'b0;
      r_out_rdata1    <= '0;
      r_out_rdata2    <= '0;
      r_out_imm       <= '0;
      r_out_pc_branch <= '0;
      r_out_pc        <= '0;
      r_out_src1      <= '0;
      r_out_src2      <= '0;
    end else if (flush) begin
      r_out_valid <= 1'b0;
    end else if (w_advance) begin
      r_out_valid     <= 1'b1;
      r_out_rdata1    <= w_rd1;
      r_out_rdata2    <= w_rd2;
      r_out_imm       <= w_imm;
      r_out_pc_branch <= w_pc_branch;
      r_out_pc        <= r_id_pc;
      r_out_src1      <= w_src1;
      r_out_src2      <= w_src2;
    end else if (!r_out_valid || out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign in_ready      = w_in_ready;
  assign out_valid     = r_out_valid;
  assign out_rdata1    = r_out_rdata1;
  assign out_rdata2    = r_out_rdata2;
  assign out_imm       = r_out_imm;
  assign out_pc_branch = r_out_pc_branch;
  assign out_pc        = r_out_pc;
  assign out_src1      = r_out_src1;
  assign out_src2      = r_out_src2;

endmodule

// File: tb/tb_decode_pipe.sv
// Directed bench for decode_pipe with a scoreboard queue; a 32-bit instance shares the control stimulus.
module tb_decode_pipe;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, in_valid, imm_size, reg_src, branch_src, flush;
  logic        wb_en, ex_load_valid, out_ready;
  logic [15:0] instr, pc, wb_data;
  logic [31:0] pc32, wb_data32;
  logic [3:0]  wb_reg, ex_load_reg;

  logic        in_ready, out_valid;
  logic [15:0] out_rdata1, out_rdata2, out_imm, out_pc_branch, out_pc;
  logic [3:0]  out_src1, out_src2;

  logic        in_ready32, o32_valid;
  logic [31:0] o32_rdata1, o32_rdata2, o32_imm, o32_pc_branch, o32_pc;
  logic [3:0]  o32_src1, o32_src2;

  assign wb_data32 = {16'h0000, wb_data};

  decode_pipe #(.DATA_W(16), .NREG_W(4)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .instr(instr), .pc(pc),
    .imm_size(imm_size), .reg_src(reg_src), .branch_src(branch_src), .flush(flush),
    .wb_en(wb_en), .wb_reg(wb_reg), .wb_data(wb_data),
    .ex_load_valid(ex_load_valid), .ex_load_reg(ex_load_reg),
    .out_valid(out_valid), .out_ready(out_ready), .out_rdata1(out_rdata1), .out_rdata2(out_rdata2),
    .out_imm(out_imm), .out_pc_branch(out_pc_branch), .out_pc(out_pc),
    .out_src1(out_src1), .out_src2(out_src2)
  );

  decode_pipe #(.DATA_W(32), .NREG_W(4)) u_dut32 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready32), .instr(instr), .pc(pc32),
    .imm_size(imm_size), .reg_src(reg_src), .branch_src(branch_src), .flush(flush),
    .wb_en(wb_en), .wb_reg(wb_reg), .wb_data(wb_data32),
    .ex_load_valid(ex_load_valid), .ex_load_reg(ex_load_reg),
    .out_valid(o32_valid), .out_ready(out_ready), .out_rdata1(o32_rdata1), .out_rdata2(o32_rdata2),
    .out_imm(o32_imm), .out_pc_branch(o32_pc_branch), .out_pc(o32_pc),
    .out_src1(o32_src1), .out_src2(o32_src2)
  );

  typedef struct {
    logic [15:0] rd1, rd2, imm, br, pc;
    logic [3:0]  s1, s2;
    logic [31:0] imm32, br32;
  } exp_t;

  exp_t        q[$];
  int          n_vec = 0;
  int          n_err = 0;
  logic [15:0] mdl [16];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input logic [15:0] rd1, rd2, imm, br, p, input logic [3:0] s1, s2,
                              input logic [31:0] imm32, br32);
    exp_t e;
    e.rd1 = rd1; e.rd2 = rd2; e.imm = imm; e.br = br; e.pc = p;
    e.s1 = s1; e.s2 = s2; e.imm32 = imm32; e.br32 = br32;
    return e;
  endfunction

  // One clock: compare a consumed output at the falling edge, then step past the rising edge.
  task automatic cycle();
    exp_t e;
    @(negedge clk);
    if (out_valid && out_ready) begin
      if (q.size() == 0) begin
        chk("unexpected_out", 32'(q.size()), 32'd1);
      end else begin
        e = q.pop_front();
        chk("rdata1", out_rdata1, e.rd1);
        chk("rdata2", out_rdata2, e.rd2);
        chk("imm", out_imm, e.imm);
        chk("pc_branch", out_pc_branch, e.br);
        chk("pc", out_pc, e.pc);
        chk("src1", out_src1, e.s1);
        chk("src2", out_src2, e.s2);
        chk("valid32", o32_valid, 1);
        chk("rdata1_32", o32_rdata1, {16'h0000, e.rd1});
        chk("rdata2_32", o32_rdata2, {16'h0000, e.rd2});
        chk("imm32", o32_imm, e.imm32);
        chk("pc_branch32", o32_pc_branch, e.br32);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wb(input logic [3:0] r, input logic [15:0] d);
    wb_en = 1'b1; wb_reg = r; wb_data = d;
    cycle();
    wb_en = 1'b0;
    if (r != 4'd0) mdl[r] = d;
  endtask

  task automatic issue(input logic [15:0] ins, input logic [15:0] p, input logic [31:0] p32,
                       input logic isz, input logic rs, input logic bs, input bit push, input exp_t e);
    in_valid = 1'b1; instr = ins; pc = p; pc32 = p32;
    imm_size = isz; reg_src = rs; branch_src = bs;
    #1;
    chk("in_ready", in_ready, 1);
    chk("in_ready32", in_ready32, 1);
    if (push) q.push_back(e);
    cycle();
    in_valid = 1'b0;
  endtask

  initial begin
    exp_t        dummy;
    logic [3:0]  a, b;
    logic [15:0] p;
    dummy = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 16; i++) mdl[i] = 16'h0000;
    rst = 1'b0; in_valid = 1'b0; imm_size = 1'b0; reg_src = 1'b0; branch_src = 1'b0; flush = 1'b0;
    wb_en = 1'b0; ex_load_valid = 1'b0; out_ready = 1'b1;
    instr = 16'h0000; pc = 16'h0000; pc32 = 32'h0; wb_data = 16'h0000; wb_reg = 4'd0; ex_load_reg = 4'd0;

    // Reset state
    cycle(); cycle();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_rdata1", out_rdata1, 0);
    chk("rst_pc_branch", out_pc_branch, 0);
    rst = 1'b1;

    // Register setup; r0 write must be ignored
    wb(4'd1, 16'h1111);
    wb(4'd2, 16'h2222);
    wb(4'd0, 16'hFFFF);

    // Back-to-back immediates, wrap, register target, r0 read
    issue(16'h01FE, 16'h0010, 32'h0000_0010, 1'b1, 1'b0, 1'b0, 1'b1,
          mk(mdl[15], mdl[14], 16'hFFFE, 16'h000C, 16'h0010, 4'hF, 4'hE, 32'hFFFF_FFFE, 32'h0000_000C));
    issue(16'h0012, 16'hFFFE, 32'h0000_FFFE, 1'b0, 1'b0, 1'b0, 1'b1,
          mk(mdl[1], mdl[2], 16'h0002, 16'h0002, 16'hFFFE, 4'h1, 4'h2, 32'h0000_0002, 32'h0001_0002));
    issue(16'h0215, 16'h0100, 32'h0000_0100, 1'b0, 1'b1, 1'b1, 1'b1,
          mk(mdl[1], mdl[2], 16'h0005, mdl[1], 16'h0100, 4'h1, 4'h2, 32'h0000_0005, {16'h0000, mdl[1]}));
    issue(16'h0103, 16'h0200, 32'h0000_0200, 1'b0, 1'b1, 1'b0, 1'b1,
          mk(16'h0000, mdl[1], 16'h0003, 16'h0206, 16'h0200, 4'h0, 4'h1, 32'h0000_0003, 32'h0000_0206));
    cycle(); cycle();
    chk("drain_a", 32'(q.size()), 0);

    // Load-use: one bubble, r3 written during the stall
    issue(16'h0030, 16'h0300, 32'h0000_0300, 1'b0, 1'b0, 1'b0, 1'b1,
          mk(16'hABCD, 16'h0000, 16'h0000, 16'h0300, 16'h0300, 4'h3, 4'h0, 32'h0, 32'h0000_0300));
    ex_load_valid = 1'b1; ex_load_reg = 4'd3;
    wb_en = 1'b1; wb_reg = 4'd3; wb_data = 16'hABCD;
    #1;
    chk("ld_in_ready", in_ready, 0);
    cycle();
    ex_load_valid = 1'b0; wb_en = 1'b0; mdl[3] = 16'hABCD;
    #1;
    chk("ld_bubble", out_valid, 0);
    chk("ld_in_ready2", in_ready, 1);
    cycle();
    chk("ld_issue", out_valid, 1);
    cycle();
    chk("drain_b", 32'(q.size()), 0);

    // Same-cycle writeback to a source register
    issue(16'h0500, 16'h0400, 32'h0000_0400, 1'b0, 1'b1, 1'b0, 1'b1,
          mk(16'h0000, 16'h1234, 16'h0000, 16'h0400, 16'h0400, 4'h0, 4'h5, 32'h0, 32'h0000_0400));
    wb_en = 1'b1; wb_reg = 4'd5; wb_data = 16'h1234;
    #1;
`ifdef DECODE_BYPASS_EN
    chk("byp_in_ready", in_ready, 1);
    cycle();
    wb_en = 1'b0; mdl[5] = 16'h1234;
    #1;
    chk("byp_valid", out_valid, 1);
`else
    chk("byp_in_ready", in_ready, 0);
    cycle();
    wb_en = 1'b0; mdl[5] = 16'h1234;
    #1;
    chk("byp_stall", out_valid, 0);
    cycle();
    chk("byp_valid", out_valid, 1);
`endif
    cycle();
    chk("drain_c", 32'(q.size()), 0);

    // Backpressure hold, then flush with a concurrent writeback
    out_ready = 1'b0;
    issue(16'h0012, 16'h0500, 32'h0000_0500, 1'b0, 1'b0, 1'b0, 1'b0, dummy);
    issue(16'h0034, 16'h0510, 32'h0000_0510, 1'b0, 1'b0, 1'b0, 1'b0, dummy);
    #1;
    chk("bp_valid", out_valid, 1);
    chk("bp_in_ready", in_ready, 0);
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("bp_hold_pc", out_pc, 16'h0500);
      chk("bp_hold_rdata1", out_rdata1, mdl[1]);
      chk("bp_hold_valid", out_valid, 1);
      chk("bp_hold_in_ready", in_ready, 0);
    end
    flush = 1'b1; in_valid = 1'b1; instr = 16'h0077;
    wb_en = 1'b1; wb_reg = 4'd7; wb_data = 16'h7777;
    #1;
    chk("fl_in_ready", in_ready, 0);
    cycle();
    flush = 1'b0; in_valid = 1'b0; wb_en = 1'b0; mdl[7] = 16'h7777;
    #1;
    chk("fl_out_valid", out_valid, 0);
    out_ready = 1'b1;
    cycle();
    chk("fl_id_cleared", out_valid, 0);
    issue(16'h0070, 16'h0600, 32'h0000_0600, 1'b0, 1'b0, 1'b0, 1'b1,
          mk(16'h7777, 16'h0000, 16'h0000, 16'h0600, 16'h0600, 4'h7, 4'h0, 32'h0, 32'h0000_0600));
    cycle(); cycle();
    chk("drain_d", 32'(q.size()), 0);

    // Reset mid-stream overriding flush and writeback
    out_ready = 1'b0;
    issue(16'h0012, 16'h0800, 32'h0000_0800, 1'b0, 1'b0, 1'b0, 1'b0, dummy);
    issue(16'h0034, 16'h0810, 32'h0000_0810, 1'b0, 1'b0, 1'b0, 1'b0, dummy);
    rst = 1'b0; flush = 1'b1; wb_en = 1'b1; wb_reg = 4'd9; wb_data = 16'h9999;
    cycle();
    rst = 1'b1; flush = 1'b0; wb_en = 1'b0;
    for (int i = 0; i < 16; i++) mdl[i] = 16'h0000;
    #1;
    chk("mrst_out_valid", out_valid, 0);
    chk("mrst_in_ready", in_ready, 1);
    chk("mrst_rdata1", out_rdata1, 0);
    chk("mrst_rdata2", out_rdata2, 0);
    chk("mrst_imm", out_imm, 0);
    chk("mrst_pc_branch", out_pc_branch, 0);
    chk("mrst_pc", out_pc, 0);
    chk("mrst_src1", out_src1, 0);
    chk("mrst_src2", out_src2, 0);
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      a = 4'(2 * i + 1);
      b = 4'(2 * i + 2);
      p = 16'h0700 + 16'(i * 16);
      issue({4'h0, b, a, 4'h0}, p, {16'h0000, p}, 1'b0, 1'b1, 1'b0, 1'b1,
            mk(16'h0000, 16'h0000, 16'h0000, p, p, a, b, 32'h0, {16'h0000, p}));
    end
    cycle(); cycle();
    chk("drain_e", 32'(q.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
